// File: rtl/sp_ram_bist_if.sv
// Request/response port of one single-port SRAM bank as seen by its initiator.
// Members keep the bank-side port names so the mux wiring reads 1:1.
interface sp_ram_bist_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  mem_en_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_we_o;
   logic [3:0]            mem_be_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport master (
      output mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/sp_ram_bist.sv
// March C- BIST initiator for one single-port SRAM bank: one access per RUN cycle,
// read data compared the cycle after each read, stops at the first mismatch.
module sp_ram_bist #(
   parameter int NUM_WORDS  = 2048,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [2:0]            fail_elem_o,
   sp_ram_bist_if.master         mem
);
   localparam int WW = $clog2(NUM_WORDS);
   localparam logic [WW-1:0] LAST = WW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

   state_e                state_q, state_d;
   logic [WW-1:0]         cnt_q, cnt_d;
   logic [2:0]            elem_q, elem_d;
   logic                  ph_q, ph_d;
   logic                  chk_vld_q, chk_vld_d;
   logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
   logic [2:0]            chk_elem_q, chk_elem_d;
   logic [WW-1:0]         chk_word_q, chk_word_d;
   logic                  pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]            fail_elem_q, fail_elem_d;

   logic          is_rd, down, bg, en, mismatch;
   logic [WW-1:0] word;

   // cnt_q always counts up; down elements walk the complement (N-1..0).
   always_comb begin
      is_rd = (elem_q == 3'd5) || ((elem_q != 3'd0) && !ph_q);
      down  = (elem_q == 3'd3) || (elem_q == 3'd4);
      word  = down ? ~cnt_q : cnt_q;
      case (elem_q)
         3'd1, 3'd3: bg = ph_q;
         3'd2, 3'd4: bg = !ph_q;
         default:    bg = 1'b0;
      endcase
      en       = (state_q == RUN);
      mismatch = chk_vld_q && (mem.mem_rdata_i != chk_exp_q);
   end

   assign mem.mem_en_o    = en;
   assign mem.mem_addr_o  = en ? ADDR_WIDTH'({word, 2'b00}) : '0;
   assign mem.mem_we_o    = en && !is_rd;
   assign mem.mem_wdata_o = (en && !is_rd) ? {DATA_WIDTH{bg}} : '0;
   assign mem.mem_be_o    = en ? 4'hF : 4'h0;

   assign busy_o      = (state_q == RUN) || (state_q == FLUSH);
   assign done_o      = (state_q == DONE);
   assign pass_o      = pass_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_elem_o = fail_elem_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      elem_d      = elem_q;
      ph_d        = ph_q;
      chk_vld_d   = 1'b0;
      chk_exp_d   = chk_exp_q;
      chk_elem_d  = chk_elem_q;
      chk_word_d  = chk_word_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d     = RUN;
               cnt_d       = '0;
               elem_d      = 3'd0;
               ph_d        = 1'b0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 3'd0;
            end
         end
         RUN: begin
            chk_vld_d  = is_rd;
            chk_exp_d  = {DATA_WIDTH{bg}};
            chk_elem_d = elem_q;
            chk_word_d = word;
            if (is_rd && elem_q != 3'd5) begin
               ph_d = 1'b1;
            end else begin
               ph_d  = 1'b0;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  elem_d = elem_q + 3'd1;
                  if (elem_q == 3'd5) state_d = FLUSH;
               end
            end
            // The access issued this cycle still goes out; nothing after it.
            if (mismatch) begin
               state_d     = DONE;
               chk_vld_d   = 1'b0;
               fail_addr_d = ADDR_WIDTH'(chk_word_q);
               fail_elem_d = chk_elem_q;
            end
         end
         FLUSH: begin
            state_d = DONE;
            pass_d  = !mismatch;
            if (mismatch) begin
               fail_addr_d = ADDR_WIDTH'(chk_word_q);
               fail_elem_d = chk_elem_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         elem_q      <= 3'd0;
         ph_q        <= 1'b0;
         chk_vld_q   <= 1'b0;
         chk_exp_q   <= '0;
         chk_elem_q  <= 3'd0;
         chk_word_q  <= '0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         elem_q      <= elem_d;
         ph_q        <= ph_d;
         chk_vld_q   <= chk_vld_d;
         chk_exp_q   <= chk_exp_d;
         chk_elem_q  <= chk_elem_d;
         chk_word_q  <= chk_word_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end
endmodule

// File: doc/sp_ram_bist.md
Name: sp_ram_bist

Overview:
- March C- built-in self-test initiator for one single-port SRAM bank.
- Drives the bank's request side: enable, byte address, write data, write enable, byte enables.
- Checks the bank's read data, which returns one cycle after a read.
- Sits between the bank and the core/debug mux.
  - While busy_o is high, the mux routes the bank port to this block.
  - Otherwise the mux routes the port to normal traffic.

Parameters:
- NUM_WORDS, 2048: number of 32-bit words tested, word addresses 0..NUM_WORDS-1 (power of two, >=2).
- DATA_WIDTH, 32: bank data width.
- ADDR_WIDTH, 16: byte-address width on mem_addr_o.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  level-sampled start request; honoured only in IDLE or DONE
- busy_o  out  1  test in progress
- done_o  out  1  test finished; held high until the next accepted start or reset
- pass_o  out  1  result, valid while done_o=1
- fail_addr_o  out  ADDR_WIDTH  word index of the first mismatch (0 if pass)
- fail_elem_o  out  3  march element (0..5) of the first mismatch
- mem_en_o  out  1  bank access enable
- mem_addr_o  out  ADDR_WIDTH  byte address = word index << 2
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_we_o  out  1  write enable (1=write, 0=read when mem_en_o=1)
- mem_be_o  out  4  byte enables; always 4'hF while mem_en_o=1, else 0
- mem_rdata_i  in  DATA_WIDTH  bank read data, valid the cycle after a read is issued

Behaviour:
- Reset, asynchronous on rstn_i low: state IDLE.
  - busy_o, done_o, pass_o, mem_en_o, mem_we_o = 0.
  - fail_addr_o, fail_elem_o, mem_addr_o, mem_wdata_o, mem_be_o = 0.
- Reset mid-test: the test aborts immediately and the bank port is released the same cycle. No partial result is retained.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE with start_i=1: next edge enters RUN with word=0, elem=0, busy_o=1.
  - done_o, pass_o, fail_* are cleared on that edge.
- Backgrounds: B0 = all zeros, B1 = all ones.
- March elements and address order:
  - E0 up: w B0
  - E1 up: r B0, w B1
  - E2 up: r B1, w B0
  - E3 down: r B0, w B1
  - E4 down: r B1, w B0
  - E5 up: r B0
- Access timing:
  - Exactly one bank access per cycle while in RUN; mem_en_o=1 every RUN cycle.
  - E0: one write per cycle.
  - E1-E4: per address, read cycle then write cycle.
  - E5: one read per cycle.
- Compare: registered expected value and element number are compared against mem_rdata_i in the cycle after each read.
- Addressing: up order counts 0..NUM_WORDS-1; down order counts NUM_WORDS-1..0. The counter wraps into the next element without idle cycles.
- After the E5 read of the last word, go to FLUSH. mem_en_o=0; the final compare happens in FLUSH. Then go to DONE.
- Total busy duration: 10*NUM_WORDS+1 cycles (RUN = 10*NUM_WORDS, FLUSH = 1).
- First mismatch:
  - Capture fail_addr_o (word index of the read) and fail_elem_o.
  - The access issued in that same cycle completes.
  - Next edge enters DONE with pass_o=0.
  - No further accesses.
- DONE: busy_o=0, done_o=1, pass_o=1 only if no mismatch occurred.
- start_i while RUN/FLUSH: ignored.

Test Plan:
- NUM_WORDS=4, fault-free bank model, pulse start_i -> busy_o high 41 cycles, then done_o=1, pass_o=1, fail_addr_o=0. Access sequence:
  - E0: 4 writes of 0 at byte addresses 0,4,8,12.
  - E3: first access is a read at byte address 12.
  - mem_be_o=4'hF on every access.
- Stuck-at-0 on bit 5 of word 2 -> first mismatch during E1 read of word 2 expecting... no: E2 read of word 2 expecting 32'hFFFFFFFF. Result: done_o=1, pass_o=0, fail_addr_o=2, fail_elem_o=2, no bank access after the cycle following detection.
- Coupling fault (write 1 to word 3 flips word 1 to 1) -> caught in E3 down-read of word 1: pass_o=0, fail_addr_o=1, fail_elem_o=3.
- Assert rstn_i low at cycle 15 of a run -> mem_en_o and busy_o drop asynchronously; after release the block stays IDLE with done_o=0 until start_i.
- start_i held high throughout run -> no restart mid-test; after DONE a new run starts next edge, clearing done_o and fail_*.
- Back-to-back runs on a fault-free bank after a failed run -> second run reports pass_o=1, fail_addr_o=0, fail_elem_o=0.
